// File: rtl/spell_mem_arbiter.sv
// spell_mem_arbiter: shares BANKS 512x8 SRAM macros between a CPU port and a
// Wishbone slave port. Every access walks IDLE -> ACCESS -> RESP -> IDLE. The
// macros are enabled during ACCESS. Read data comes out of the macro during
// RESP and is captured on the edge that leaves RESP. The ack is raised on that
// same edge, two edges after the request was sampled.
// Optional feature macro: SPELL_MEM_ARB_RR_EN. When it is defined, ties are
// broken round-robin. When it is not defined, the Wishbone port always wins a tie.
module spell_mem_arbiter #(
    parameter int unsigned BANKS   = 2,
    parameter logic [31:0] WB_BASE = 32'h3000_0000,
    localparam int unsigned AW     = 9 + $clog2(BANKS)
) (
    input  logic               clock,
    input  logic               reset,
    // CPU port
    input  logic               core_req,
    input  logic               core_we,
    input  logic [AW-1:0]      core_addr,
    input  logic [7:0]         core_wdata,
    output logic               core_ack,
    output logic [7:0]         core_rdata,
    // Wishbone slave port
    input  logic               i_wb_cyc,
    input  logic               i_wb_stb,
    input  logic               i_wb_we,
    input  logic [31:0]        i_wb_addr,
    input  logic [31:0]        i_wb_data,
    output logic               o_wb_ack,
    output logic [31:0]        o_wb_data,
    // SRAM macros (all enables active-low)
    output logic [8:0]         sram_a,
    output logic [7:0]         sram_d,
    output logic               sram_gwen,
    output logic [7:0]         sram_wen,
    output logic [BANKS-1:0]   sram_cen,
    input  logic [8*BANKS-1:0] sram_q
);

    localparam int unsigned BW = (BANKS > 1) ? $clog2(BANKS) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state_r;
    logic             gnt_wb_r;
    logic             we_r;
    logic [7:0]       wdata_r;
    logic [BW-1:0]    bank_r;
`ifdef SPELL_MEM_ARB_RR_EN
    logic             last_wb_r;
`endif

    logic             core_v_s;
    logic             wb_v_s;
    logic             pick_wb_s;
    logic [AW-1:0]    sel_addr_s;
    logic             sel_we_s;
    logic [7:0]       sel_wdata_s;
    logic [BW-1:0]    sel_bank_s;
    logic [BANKS-1:0] cen_next_s;
    logic [7:0]       q_byte_s;
    logic [7:0]       resp_byte_s;
    logic             unused_s;

    // The design ignores the upper Wishbone address bits below the decoded byte and the upper write-data bits.
    assign unused_s = ^{i_wb_addr[23:AW], i_wb_data[31:8]};

    // Qualify the requests, break ties, and mux the winner's address and data.
    always_comb begin
        core_v_s = core_req;
        wb_v_s   = i_wb_cyc & i_wb_stb & (i_wb_addr[31:24] == WB_BASE[31:24]);
`ifdef SPELL_MEM_ARB_RR_EN
        if (core_v_s && wb_v_s) begin
            pick_wb_s = ~last_wb_r;
        end else begin
            pick_wb_s = wb_v_s;
        end
`else
        pick_wb_s = wb_v_s;
`endif
        if (pick_wb_s) begin
            sel_addr_s  = i_wb_addr[AW-1:0];
            sel_we_s    = i_wb_we;
            sel_wdata_s = i_wb_data[7:0];
        end else begin
            sel_addr_s  = core_addr;
            sel_we_s    = core_we;
            sel_wdata_s = core_wdata;
        end
    end

    // Bank index is the address bits above the 512-byte macro. A single bank has no index bits.
    generate
        if (BANKS > 1) begin : g_multi_bank
            assign sel_bank_s = sel_addr_s[AW-1:9];
        end else begin : g_single_bank
            assign sel_bank_s = '0;
        end
    endgenerate

    // Build the active-low chip enable for the chosen bank and pick the bank's read byte.
    always_comb begin
        cen_next_s = '1;
        q_byte_s   = 8'h00;
        for (int b = 0; b < BANKS; b++) begin
            cen_next_s[b] = (sel_bank_s != BW'(b));
            q_byte_s      = q_byte_s | ({8{bank_r == BW'(b)}} & sram_q[8*b +: 8]);
        end
        resp_byte_s = we_r ? wdata_r : q_byte_s;
    end

    // Access FSM with registered SRAM controls and responses.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            gnt_wb_r   <= 1'b0;
            we_r       <= 1'b0;
            wdata_r    <= 8'h00;
            bank_r     <= '0;
            core_ack   <= 1'b0;
            core_rdata <= 8'h00;
            o_wb_ack   <= 1'b0;
            o_wb_data  <= 32'h0000_0000;
            sram_a     <= 9'h000;
            sram_d     <= 8'h00;
            sram_gwen  <= 1'b1;
            sram_wen   <= 8'hFF;
            sram_cen   <= '1;
`ifdef SPELL_MEM_ARB_RR_EN
            last_wb_r  <= 1'b0;
`endif
        end else begin
            core_ack <= 1'b0;
            o_wb_ack <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (core_v_s || wb_v_s) begin
                        state_r   <= ACCESS;
                        gnt_wb_r  <= pick_wb_s;
                        we_r      <= sel_we_s;
                        wdata_r   <= sel_wdata_s;
                        bank_r    <= sel_bank_s;
                        sram_a    <= sel_addr_s[8:0];
                        sram_d    <= sel_wdata_s;
                        sram_gwen <= ~sel_we_s;
                        sram_wen  <= sel_we_s ? 8'h00 : 8'hFF;
                        sram_cen  <= cen_next_s;
`ifdef SPELL_MEM_ARB_RR_EN
                        last_wb_r <= pick_wb_s;
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    state_r   <= RESP;
                    sram_gwen <= 1'b1;
                    sram_wen  <= 8'hFF;
                    sram_cen  <= '1;
                end
                RESP: begin
                    // Requests are not sampled here, so a held request is serviced once per pass.
                    state_r <= IDLE;
                    if (gnt_wb_r) begin
                        o_wb_ack  <= 1'b1;
                        o_wb_data <= {24'h00_0000, resp_byte_s};
                    end else begin
                        core_ack   <= 1'b1;
                        core_rdata <= resp_byte_s;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    sram_gwen <= 1'b1;
                    sram_wen  <= 8'hFF;
                    sram_cen  <= '1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spell_mem_arbiter.sv
// Scoreboard bench for spell_mem_arbiter: a BANKS=2 instance backed by a small
// SRAM model, plus a BANKS=4 instance fed with a fixed sram_q pattern.
module tb_spell_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;

    logic        core_req, core_we, core_ack;
    logic [9:0]  core_addr;
    logic [7:0]  core_wdata, core_rdata;
    logic        i_wb_cyc, i_wb_stb, i_wb_we, o_wb_ack;
    logic [31:0] i_wb_addr, i_wb_data, o_wb_data;
    logic [8:0]  sram_a;
    logic [7:0]  sram_d, sram_wen;
    logic        sram_gwen;
    logic [1:0]  sram_cen;
    logic [15:0] sram_q;

    logic        b4_req, b4_we, b4_ack, b4_wb_ack;
    logic [10:0] b4_addr;
    logic [7:0]  b4_wdata, b4_rdata, b4_d, b4_wen;
    logic [31:0] b4_wb_data;
    logic [8:0]  b4_a;
    logic        b4_gwen;
    logic [3:0]  b4_cen;
    logic [31:0] b4_q;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_core_q[$];
    logic [31:0] exp_wb_q[$];
    logic [31:0] exp_b4_q[$];
    logic [7:0]  mem [2][512];

    spell_mem_arbiter #(.BANKS(2)) dut (
        .clock(clock), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_ack(core_ack), .core_rdata(core_rdata),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we),
        .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data),
        .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
        .sram_a(sram_a), .sram_d(sram_d), .sram_gwen(sram_gwen),
        .sram_wen(sram_wen), .sram_cen(sram_cen), .sram_q(sram_q)
    );

    spell_mem_arbiter #(.BANKS(4)) dut4 (
        .clock(clock), .reset(reset),
        .core_req(b4_req), .core_we(b4_we), .core_addr(b4_addr),
        .core_wdata(b4_wdata), .core_ack(b4_ack), .core_rdata(b4_rdata),
        .i_wb_cyc(1'b0), .i_wb_stb(1'b0), .i_wb_we(1'b0),
        .i_wb_addr(32'h0000_0000), .i_wb_data(32'h0000_0000),
        .o_wb_ack(b4_wb_ack), .o_wb_data(b4_wb_data),
        .sram_a(b4_a), .sram_d(b4_d), .sram_gwen(b4_gwen),
        .sram_wen(b4_wen), .sram_cen(b4_cen), .sram_q(b4_q)
    );

    always #5 clock = ~clock;

    assign b4_q = 32'hC3_5A_11_22;

    // Behavioural synchronous SRAM: read data appears the cycle after an enabled edge.
    always @(posedge clock) begin
        for (int b = 0; b < 2; b++) begin
            if (!sram_cen[b]) begin
                if (!sram_gwen) mem[b][sram_a] <= (mem[b][sram_a] & sram_wen) | (sram_d & ~sram_wen);
                sram_q[8*b +: 8] <= mem[b][sram_a];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every ack pops the matching scoreboard queue and compares the data.
    always @(negedge clock) begin
        if (core_ack === 1'b1) begin
            if (exp_core_q.size() == 0) chk("core_ack_unexpected", {31'h0, core_ack}, 32'd0);
            else chk("core_rdata", {24'h0, core_rdata}, exp_core_q.pop_front());
        end
        if (o_wb_ack === 1'b1) begin
            if (exp_wb_q.size() == 0) chk("wb_ack_unexpected", {31'h0, o_wb_ack}, 32'd0);
            else chk("wb_data", o_wb_data, exp_wb_q.pop_front());
        end
        if (b4_ack === 1'b1) begin
            if (exp_b4_q.size() == 0) chk("b4_ack_unexpected", {31'h0, b4_ack}, 32'd0);
            else chk("b4_rdata", {24'h0, b4_rdata}, exp_b4_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drop(input bit wb);
        if (wb) begin
            i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        end else begin
            core_req = 1'b0; core_we = 1'b0;
        end
    endtask

    // Present a request and push its expected response. Returns just after the sampling edge.
    task automatic start_req(input bit wb, input bit we, input logic [31:0] addr,
                             input logic [7:0] wd, input logic [7:0] exp);
        if (wb) begin
            exp_wb_q.push_back({24'h0, exp});
            i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we;
            i_wb_addr = addr; i_wb_data = {24'hDEADBE, wd};
        end else begin
            exp_core_q.push_back({24'h0, exp});
            core_req = 1'b1; core_we = we; core_addr = addr[9:0]; core_wdata = wd;
        end
        tick();
    endtask

    // The ack must be low one edge after sampling and high on the second edge, for exactly one cycle.
    task automatic finish_req(input bit wb, input string tag);
        tick();
        chk({tag, "_lat1"}, {31'h0, wb ? o_wb_ack : core_ack}, 32'd0);
        tick();
        chk({tag, "_lat2"}, {31'h0, wb ? o_wb_ack : core_ack}, 32'd1);
        drop(wb);
        tick();
        chk({tag, "_pulse"}, {31'h0, wb ? o_wb_ack : core_ack}, 32'd0);
    endtask

    initial begin
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < 512; i++) mem[b][i] = 8'h00;
        reset = 1'b1;
        core_req = 1'b0; core_we = 1'b0; core_addr = 10'h000; core_wdata = 8'h00;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        i_wb_addr = 32'h0; i_wb_data = 32'h0;
        b4_req = 1'b0; b4_we = 1'b0; b4_addr = 11'h000; b4_wdata = 8'h00;
        tick();
        tick();
        chk("rst_acks", {30'h0, core_ack, o_wb_ack}, 32'd0);
        chk("rst_rdata", {core_rdata, 24'h0}, 32'd0);
        chk("rst_wbdata", o_wb_data, 32'd0);
        chk("rst_sram_ctl", {21'h0, sram_cen, sram_gwen, sram_wen}, {21'h0, 2'b11, 1'b1, 8'hFF});
        chk("rst_sram_ad", {15'h0, sram_a, sram_d}, 32'd0);
        reset = 1'b0;

        // Core write 0xA5 to 0x205: bank 1, row 0x005.
        start_req(1'b0, 1'b1, 32'h205, 8'hA5, 8'hA5);
        chk("cw_cen", {30'h0, sram_cen}, 32'h1);
        chk("cw_a", {23'h0, sram_a}, 32'h005);
        chk("cw_d", {24'h0, sram_d}, 32'hA5);
        chk("cw_we", {23'h0, sram_gwen, sram_wen}, 32'h000);
        finish_req(1'b0, "cw");
        chk("cw_idle_cen", {30'h0, sram_cen}, 32'h3);

        // Wishbone read of 0x3000_0205 returns the byte just written.
        start_req(1'b1, 1'b0, 32'h3000_0205, 8'h00, 8'hA5);
        chk("wr_cen", {30'h0, sram_cen}, 32'h1);
        chk("wr_rd_ctl", {23'h0, sram_gwen, sram_wen}, 32'h1FF);
        finish_req(1'b1, "wr");

        // Wishbone write 0x77 to 0x3000_0010: bank 0.
        start_req(1'b1, 1'b1, 32'h3000_0010, 8'h77, 8'h77);
        chk("ww_cen", {30'h0, sram_cen}, 32'h2);
        finish_req(1'b1, "ww");
        chk("core_rdata_hold", {24'h0, core_rdata}, 32'hA5);

        // Core read of 0x010.
        start_req(1'b0, 1'b0, 32'h010, 8'h00, 8'h77);
        finish_req(1'b0, "cr");
        chk("wb_data_hold", o_wb_data, 32'h77);

        // Out-of-window Wishbone request: never served and does not block the core.
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = 32'h2000_0010;
        tick();
        chk("oow_idle1", {30'h0, sram_cen}, 32'h3);
        tick();
        chk("oow_idle2", {30'h0, sram_cen}, 32'h3);
        start_req(1'b0, 1'b0, 32'h205, 8'h00, 8'hA5);
        chk("oow_core_cen", {30'h0, sram_cen}, 32'h1);
        finish_req(1'b0, "oow_core");
        chk("oow_no_ack", {31'h0, o_wb_ack}, 32'd0);
        drop(1'b1);

        // Both ports held: core reads 0x010 (bank 0), Wishbone reads 0x3000_0205 (bank 1).
`ifdef SPELL_MEM_ARB_RR_EN
        exp_wb_q.push_back(32'hA5); exp_wb_q.push_back(32'hA5);
        exp_core_q.push_back(32'h77); exp_core_q.push_back(32'h77);
`else
        for (int i = 0; i < 4; i++) exp_wb_q.push_back(32'hA5);
`endif
        core_req = 1'b1; core_we = 1'b0; core_addr = 10'h010;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = 32'h3000_0205;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (k % 3 == 1) begin
`ifdef SPELL_MEM_ARB_RR_EN
                chk($sformatf("tie_grant_%0d", k), {30'h0, sram_cen}, (k % 6 == 1) ? 32'h1 : 32'h2);
`else
                chk($sformatf("tie_grant_%0d", k), {30'h0, sram_cen}, 32'h1);
`endif
            end
        end
        drop(1'b0);
        drop(1'b1);
        tick();
        chk("tie_quiet", {30'h0, core_ack, o_wb_ack}, 32'd0);

        // Reset in ACCESS aborts the access; the held request is served again afterwards.
        start_req(1'b0, 1'b0, 32'h205, 8'h00, 8'hA5);
        chk("ra_access_cen", {30'h0, sram_cen}, 32'h1);
        reset = 1'b1;
        tick();
        chk("ra_abort_cen", {30'h0, sram_cen}, 32'h3);
        chk("ra_abort_ack", {31'h0, core_ack}, 32'd0);
        reset = 1'b0;
        tick();
        chk("ra_regrant_cen", {30'h0, sram_cen}, 32'h1);
        finish_req(1'b0, "ra");

        // BANKS=4: core read of 0x7FF selects bank 3 and sram_q[31:24].
        exp_b4_q.push_back(32'hC3);
        b4_req = 1'b1; b4_we = 1'b0; b4_addr = 11'h7FF;
        tick();
        chk("b4_cen", {28'h0, b4_cen}, 32'h7);
        chk("b4_a", {23'h0, b4_a}, 32'h1FF);
        tick();
        chk("b4_lat1", {31'h0, b4_ack}, 32'd0);
        tick();
        chk("b4_lat2", {31'h0, b4_ack}, 32'd1);
        b4_req = 1'b0;
        tick();
        chk("b4_pulse", {31'h0, b4_ack}, 32'd0);
        chk("b4_no_wb", {31'h0, b4_wb_ack}, 32'd0);

        tick();
        chk("drain_core", exp_core_q.size(), 32'd0);
        chk("drain_wb", exp_wb_q.size(), 32'd0);
        chk("drain_b4", exp_b4_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
